// File: rtl/mod_inv_scalar.sv
// Modular inverse w = a^-1 mod MOD using binary extended Euclid, one step per clock.
// Out-of-range operands (0 or >= MOD) finish early with fail set and result forced to 0.
module mod_inv_scalar #(
    parameter int unsigned      WIDTH = 256,
    parameter logic [WIDTH-1:0] MOD   =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             fail
);

    typedef enum logic [1:0] {StIdle, StCheck, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] u_q, u_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] x1_q, x1_d;
    logic [WIDTH-1:0] x2_q, x2_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             fail_q, fail_d;

    // x/2 mod MOD; odd x gets MOD added at WIDTH+1 bits so the shift is exact.
    function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x);
        return WIDTH'(({1'b0, x} + (x[0] ? {1'b0, MOD} : '0)) >> 1);
    endfunction

    // (x - y) mod MOD for x, y in [0, MOD-1]; a borrow is repaid with MOD.
    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        return WIDTH'({1'b0, x} - {1'b0, y} + ((x < y) ? {1'b0, MOD} : '0));
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            res_q   <= '0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            u_q     <= u_d;
            v_q     <= v_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            res_q   <= res_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        u_d     = u_q;
        v_d     = v_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        res_d   = res_q;
        fail_d  = fail_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (a_q == '0 || a_q >= MOD) begin
                    fail_d  = 1'b1;
                    res_d   = '0;
                    state_d = StDone;
                end else begin
                    u_d     = a_q;
                    v_d     = MOD;
                    x1_d    = WIDTH'(1);
                    x2_d    = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (u_q == WIDTH'(1)) begin
                    res_d   = x1_q;
                    state_d = StDone;
                end else if (v_q == WIDTH'(1)) begin
                    res_d   = x2_q;
                    state_d = StDone;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = half_mod(x1_q);
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = half_mod(x2_q);
                end else if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = sub_mod(x1_q, x2_q);
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = sub_mod(x2_q, x1_q);
                end
            end
            StDone: begin
                res_d   = '0;
                fail_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = out_valid ? res_q : '0;
    assign fail      = out_valid & fail_q;

endmodule

// File: tb/tb_mod_inv_scalar.sv
// Directed and randomised checks of mod_inv_scalar against hand-computed inverses and
// an independent multiply-and-reduce check of a * result mod N.
module tb_mod_inv_scalar;

    localparam int unsigned W = 256;
    localparam logic [W-1:0] N =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;
    localparam logic [W-1:0] INV2 =
        256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_5D576E73_57A4501D_DFE92F46_681B20A1;
    localparam int MAX_LAT = 1027;
    localparam int TIMEOUT = 1100;
    localparam int NUM_RANDOM = 40;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic         busy;
    logic         out_valid;
    logic [W-1:0] result;
    logic         fail;

    int tests = 0;
    int fails = 0;

    mod_inv_scalar #(
        .WIDTH(W),
        .MOD  (N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .busy     (busy),
        .out_valid(out_valid),
        .result   (result),
        .fail     (fail)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        return W'(p % {{W{1'b0}}, N});
    endfunction

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] r;
        do begin
            r = '0;
            for (int i = 0; i < 8; i++) r = {r[W-33:0], 32'($urandom())};
        end while (r == '0 || r >= N);
        return r;
    endfunction

    // Issue one operation and wait for its strobe; returns one cycle after DONE (IDLE).
    // lat counts clocks from the in_valid sampling edge's cycle to the out_valid cycle.
    task automatic run_op(input logic [W-1:0] val, input bit extra,
                          output logic [W-1:0] res, output logic fl, output int lat);
        in_valid = 1'b1;
        a        = val;
        tick();
        in_valid = 1'b0;
        a        = '0;
        lat      = 1;
        while (!out_valid && lat < TIMEOUT) begin
            if (extra && lat == 5) begin
                in_valid = 1'b1;
                a        = val ^ 256'h5;
            end
            tick();
            in_valid = 1'b0;
            a        = '0;
            lat++;
        end
        res = result;
        fl  = fail;
        if (!out_valid) lat = TIMEOUT + 1;
        tick();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 256'd5;
        tick();
        tick();
        tests++; if (busy !== 1'b0) begin fails++;
            $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (out_valid !== 1'b0) begin fails++;
            $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (result !== '0) begin fails++;
            $display("FAIL reset_result got %h want 0", result); end
        tests++; if (fail !== 1'b0) begin fails++;
            $display("FAIL reset_fail got %b want 0", fail); end
        in_valid = 1'b0;
        a        = '0;
        rst_n    = 1'b1;
        tick();
    endtask

    task automatic test_one();
        logic [W-1:0] res; logic fl; int lat;
        run_op(256'd1, 1'b0, res, fl, lat);
        tests++; if (lat !== 3) begin fails++;
            $display("FAIL one_latency got %0d want 3", lat); end
        tests++; if (res !== 256'd1) begin fails++;
            $display("FAIL one_result got %h want 1", res); end
        tests++; if (fl !== 1'b0) begin fails++;
            $display("FAIL one_fail got %b want 0", fl); end
    endtask

    task automatic test_known_values();
        logic [W-1:0] res; logic fl; int lat;
        run_op(256'd2, 1'b0, res, fl, lat);
        tests++; if (res !== INV2) begin fails++;
            $display("FAIL two_result got %h want %h", res, INV2); end
        tests++; if (fl !== 1'b0) begin fails++;
            $display("FAIL two_fail got %b want 0", fl); end
        run_op(N - 256'd1, 1'b0, res, fl, lat);
        tests++; if (res !== N - 256'd1) begin fails++;
            $display("FAIL nm1_result got %h want %h", res, N - 256'd1); end
        tests++; if (fl !== 1'b0) begin fails++;
            $display("FAIL nm1_fail got %b want 0", fl); end
        tests++; if (lat > MAX_LAT) begin fails++;
            $display("FAIL nm1_latency got %0d want <= %0d", lat, MAX_LAT); end
    endtask

    task automatic test_range_fail();
        logic [W-1:0] res; logic fl; int lat;
        run_op('0, 1'b0, res, fl, lat);
        tests++; if (fl !== 1'b1) begin fails++;
            $display("FAIL zero_fail got %b want 1", fl); end
        tests++; if (res !== '0) begin fails++;
            $display("FAIL zero_result got %h want 0", res); end
        tests++; if (lat !== 2) begin fails++;
            $display("FAIL zero_latency got %0d want 2", lat); end
        run_op(N, 1'b0, res, fl, lat);
        tests++; if (fl !== 1'b1) begin fails++;
            $display("FAIL modn_fail got %b want 1", fl); end
        tests++; if (res !== '0) begin fails++;
            $display("FAIL modn_result got %h want 0", res); end
        tests++; if (lat !== 2) begin fails++;
            $display("FAIL modn_latency got %0d want 2", lat); end
    endtask

    task automatic test_mid_run_reset();
        logic [W-1:0] res; logic fl; int lat;
        bit seen;
        in_valid = 1'b1;
        a        = 256'd5;
        tick();
        in_valid = 1'b0;
        a        = '0;
        tick();
        repeat (99) tick();
        tests++; if (busy !== 1'b1 || out_valid !== 1'b0) begin fails++;
            $display("FAIL midrun_busy got busy=%b ov=%b want 1/0", busy, out_valid); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests++; if ({busy, out_valid, fail} !== 3'b000 || result !== '0) begin fails++;
            $display("FAIL midrun_reset_outputs got busy=%b ov=%b fail=%b res=%h want 0",
                     busy, out_valid, fail, result); end
        seen = 1'b0;
        repeat (TIMEOUT) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++;
            $display("FAIL midrun_no_strobe got out_valid seen=%b want 0", seen); end
        run_op(256'd3, 1'b0, res, fl, lat);
        tests++; if (mulmod(256'd3, res) !== 256'd1 || fl !== 1'b0) begin fails++;
            $display("FAIL three_inverse got res=%h fail=%b want 3*res mod N == 1", res, fl);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] val, res; logic fl; int lat;
        bit seen;
        for (int i = 0; i < NUM_RANDOM; i++) begin
            val = rand_operand();
            run_op(val, 1'b1, res, fl, lat);
            tests++; if (mulmod(val, res) !== 256'd1 || fl !== 1'b0) begin fails++;
                $display("FAIL rand_inverse[%0d] a=%h got res=%h fail=%b", i, val, res, fl);
            end
            tests++; if (lat > MAX_LAT) begin fails++;
                $display("FAIL rand_latency[%0d] got %0d want <= %0d", i, lat, MAX_LAT); end
            tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++;
                $display("FAIL rand_idle[%0d] got busy=%b ov=%b want 0/0", i, busy, out_valid);
            end
        end
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (out_valid || busy) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++;
            $display("FAIL extra_pulse_dropped got activity=%b want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_one();
        test_known_values();
        test_range_fail();
        test_mid_run_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
